// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU/branch ops, snoops both
// result buses for missing operands and issues one ready op per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE  = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_pipline,
  input  logic                dispatch_valid,
  input  logic [ID_WIDTH-1:0] dispatch_id,
  input  logic [6:0]          dispatch_opcode,
  input  logic [2:0]          dispatch_funct3,
  input  logic [6:0]          dispatch_funct7,
  input  logic [31:0]         dispatch_imm,
  input  logic [5:0]          dispatch_shamt,
  input  logic [31:0]         dispatch_pc,
  input  logic                dispatch_rs1_ready,
  input  logic                dispatch_rs2_ready,
  input  logic [31:0]         dispatch_rs1_val,
  input  logic [31:0]         dispatch_rs2_val,
  input  logic [ID_WIDTH-1:0] dispatch_rs1_dep,
  input  logic [ID_WIDTH-1:0] dispatch_rs2_dep,
  input  logic                alu_cdb_valid,
  input  logic [ID_WIDTH-1:0] alu_cdb_id,
  input  logic [31:0]         alu_cdb_val,
  input  logic                lsb_cdb_valid,
  input  logic [ID_WIDTH-1:0] lsb_cdb_id,
  input  logic [31:0]         lsb_cdb_val,
  output logic                rs_full,
  output logic                have_ins,
  output logic [ID_WIDTH-1:0] ins_id,
  output logic [31:0]         rs1_val,
  output logic [31:0]         rs2_val,
  output logic [31:0]         imm_val,
  output logic [5:0]          shamt_val,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [31:0]         request_PC
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] tag;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic [5:0]          shamt;
    logic [31:0]         pc;
    logic                rs1_rdy;
    logic [31:0]         rs1_val;
    logic [ID_WIDTH-1:0] rs1_dep;
    logic                rs2_rdy;
    logic [31:0]         rs2_val;
    logic [ID_WIDTH-1:0] rs2_dep;
  } entry_t;

  logic [RS_SIZE-1:0] busy;
  entry_t             ent [RS_SIZE];
  entry_t             new_ent;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      iss_idx;
  logic               free_found;
  logic               iss_found;
  logic [CW-1:0]      busy_cnt;

  // ALU bus wins if both buses carry the operand's tag.
  function automatic logic [32:0] snoop(
    input logic                rdy,
    input logic [31:0]         val,
    input logic [ID_WIDTH-1:0] dep
  );
    logic [32:0] r;
    r = {rdy, val};
    if (!rdy) begin
      if (alu_cdb_valid && alu_cdb_id == dep)
        r = {1'b1, alu_cdb_val};
      else if (lsb_cdb_valid && lsb_cdb_id == dep)
        r = {1'b1, lsb_cdb_val};
    end
    return r;
  endfunction

  // Descending scan leaves the lowest index as the winner.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    iss_idx    = '0;
    iss_found  = 1'b0;
    busy_cnt   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
      if (busy[i] && ent[i].rs1_rdy && ent[i].rs2_rdy) begin
        iss_idx   = IW'(i);
        iss_found = 1'b1;
      end
    end
    for (int i = 0; i < RS_SIZE; i++)
      busy_cnt = busy_cnt + CW'(busy[i]);
  end

  assign rs_full = (busy_cnt == CW'(RS_SIZE));

  always_comb begin
    new_ent         = '0;
    new_ent.tag     = dispatch_id;
    new_ent.opcode  = dispatch_opcode;
    new_ent.funct3  = dispatch_funct3;
    new_ent.funct7  = dispatch_funct7;
    new_ent.imm     = dispatch_imm;
    new_ent.shamt   = dispatch_shamt;
    new_ent.pc      = dispatch_pc;
    new_ent.rs1_dep = dispatch_rs1_dep;
    new_ent.rs2_dep = dispatch_rs2_dep;
    {new_ent.rs1_rdy, new_ent.rs1_val} =
      snoop(dispatch_rs1_ready, dispatch_rs1_val,
            dispatch_rs1_dep);
    {new_ent.rs2_rdy, new_ent.rs2_val} =
      snoop(dispatch_rs2_ready, dispatch_rs2_val,
            dispatch_rs2_dep);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy <= '0;
      for (int i = 0; i < RS_SIZE; i++)
        ent[i] <= '0;
      have_ins   <= 1'b0;
      ins_id     <= '0;
      rs1_val    <= '0;
      rs2_val    <= '0;
      imm_val    <= '0;
      shamt_val  <= '0;
      opcode     <= '0;
      funct3     <= '0;
      funct7     <= '0;
      request_PC <= '0;
    end else if (!rdy_in) begin
      have_ins <= 1'b0;
    end else if (flush_pipline) begin
      busy     <= '0;
      have_ins <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {ent[i].rs1_rdy, ent[i].rs1_val} <=
            snoop(ent[i].rs1_rdy, ent[i].rs1_val,
                  ent[i].rs1_dep);
          {ent[i].rs2_rdy, ent[i].rs2_val} <=
            snoop(ent[i].rs2_rdy, ent[i].rs2_val,
                  ent[i].rs2_dep);
        end
      end
      have_ins <= iss_found;
      if (iss_found) begin
        busy[iss_idx] <= 1'b0;
        ins_id        <= ent[iss_idx].tag;
        rs1_val       <= ent[iss_idx].rs1_val;
        rs2_val       <= ent[iss_idx].rs2_val;
        imm_val       <= ent[iss_idx].imm;
        shamt_val     <= ent[iss_idx].shamt;
        opcode        <= ent[iss_idx].opcode;
        funct3        <= ent[iss_idx].funct3;
        funct7        <= ent[iss_idx].funct7;
        request_PC    <= ent[iss_idx].pc;
      end
      // free_idx comes from start-of-cycle busy, so a slot
      // vacated by this edge's issue is not refilled yet.
      if (dispatch_valid && !rs_full && free_found) begin
        busy[free_idx] <= 1'b1;
        ent[free_idx]  <= new_ent;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: vector table, directed
// corner sequences and a randomized run against a slot model.
module tb_alu_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_pipline;
  logic        dispatch_valid;
  logic [2:0]  dispatch_id;
  logic [6:0]  dispatch_opcode;
  logic [2:0]  dispatch_funct3;
  logic [6:0]  dispatch_funct7;
  logic [31:0] dispatch_imm;
  logic [5:0]  dispatch_shamt;
  logic [31:0] dispatch_pc;
  logic        dispatch_rs1_ready;
  logic        dispatch_rs2_ready;
  logic [31:0] dispatch_rs1_val;
  logic [31:0] dispatch_rs2_val;
  logic [2:0]  dispatch_rs1_dep;
  logic [2:0]  dispatch_rs2_dep;
  logic        alu_cdb_valid;
  logic [2:0]  alu_cdb_id;
  logic [31:0] alu_cdb_val;
  logic        lsb_cdb_valid;
  logic [2:0]  lsb_cdb_id;
  logic [31:0] lsb_cdb_val;
  logic        rs_full;
  logic        have_ins;
  logic [2:0]  ins_id;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_val;
  logic [5:0]  shamt_val;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] request_PC;

  int total = 0;
  int bad = 0;

  alu_reservation_station #(.RS_SIZE(4), .ID_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush_pipline(flush_pipline),
    .dispatch_valid(dispatch_valid),
    .dispatch_id(dispatch_id),
    .dispatch_opcode(dispatch_opcode),
    .dispatch_funct3(dispatch_funct3),
    .dispatch_funct7(dispatch_funct7),
    .dispatch_imm(dispatch_imm),
    .dispatch_shamt(dispatch_shamt),
    .dispatch_pc(dispatch_pc),
    .dispatch_rs1_ready(dispatch_rs1_ready),
    .dispatch_rs2_ready(dispatch_rs2_ready),
    .dispatch_rs1_val(dispatch_rs1_val),
    .dispatch_rs2_val(dispatch_rs2_val),
    .dispatch_rs1_dep(dispatch_rs1_dep),
    .dispatch_rs2_dep(dispatch_rs2_dep),
    .alu_cdb_valid(alu_cdb_valid),
    .alu_cdb_id(alu_cdb_id),
    .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid),
    .lsb_cdb_id(lsb_cdb_id),
    .lsb_cdb_val(lsb_cdb_val),
    .rs_full(rs_full), .have_ins(have_ins),
    .ins_id(ins_id), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .imm_val(imm_val),
    .shamt_val(shamt_val), .opcode(opcode),
    .funct3(funct3), .funct7(funct7),
    .request_PC(request_PC)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  id;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [5:0]  sh;
    logic [31:0] pc;
    logic        r1r;
    logic [31:0] r1v;
    logic [2:0]  r1d;
    logic        r2r;
    logic [31:0] r2v;
    logic [2:0]  r2d;
    int          bus;
    logic [2:0]  bid;
    logic [31:0] bval;
    logic [31:0] e1;
    logic [31:0] e2;
    int          lat;
  } vec_t;

  typedef struct {
    bit          busy;
    logic [2:0]  id;
    logic [31:0] imm;
    logic        r1;
    logic        r2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  d1;
    logic [2:0]  d2;
  } ment_t;

  vec_t  vt [6];
  ment_t m [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1;
    flush_pipline = 1'b0;
    dispatch_valid = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
  endtask

  task automatic disp(input logic [2:0] id,
                      input logic r1r, input logic [31:0] r1v,
                      input logic [2:0] r1d,
                      input logic r2r, input logic [31:0] r2v,
                      input logic [2:0] r2d,
                      input logic [31:0] imm);
    dispatch_valid = 1'b1;
    dispatch_id = id;
    dispatch_opcode = 7'h33;
    dispatch_funct3 = 3'd0;
    dispatch_funct7 = 7'd0;
    dispatch_shamt = 6'd0;
    dispatch_imm = imm;
    dispatch_pc = 32'h1000 + 32'(id);
    dispatch_rs1_ready = r1r;
    dispatch_rs1_val = r1v;
    dispatch_rs1_dep = r1d;
    dispatch_rs2_ready = r2r;
    dispatch_rs2_val = r2v;
    dispatch_rs2_dep = r2d;
  endtask

  // Operand as seen after this edge's broadcasts (ALU bus first).
  function automatic logic [32:0] res(input logic r,
                                      input logic [31:0] v,
                                      input logic [2:0] d);
    if (r) return {1'b1, v};
    if (alu_cdb_valid && alu_cdb_id == d)
      return {1'b1, alu_cdb_val};
    if (lsb_cdb_valid && lsb_cdb_id == d)
      return {1'b1, lsb_cdb_val};
    return {1'b0, v};
  endfunction

  initial begin
    int lat, nstrb;
    logic [31:0] c_id, c1, c2, c_imm, c_pc, c_dec;

    idle();
    dispatch_id = '0; dispatch_opcode = '0;
    dispatch_funct3 = '0; dispatch_funct7 = '0;
    dispatch_imm = '0; dispatch_shamt = '0; dispatch_pc = '0;
    dispatch_rs1_ready = 0; dispatch_rs2_ready = 0;
    dispatch_rs1_val = '0; dispatch_rs2_val = '0;
    dispatch_rs1_dep = '0; dispatch_rs2_dep = '0;
    alu_cdb_id = '0; alu_cdb_val = '0;
    lsb_cdb_id = '0; lsb_cdb_val = '0;
    rst_in = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    chk("rst_have", 32'(have_ins), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_id", 32'(ins_id), 0);
    chk("rst_rs1", rs1_val, 0);
    chk("rst_rs2", rs2_val, 0);
    chk("rst_imm", imm_val, 0);
    chk("rst_pc", request_PC, 0);
    chk("rst_dec", 32'({opcode, funct3, funct7, shamt_val}), 0);
    step();
    step();
    rst_in = 1'b0;
    step();

    // bus: 0 none, 1 ALU wake, 2 LSB wake, 3 ALU bypass, 4 LSB bypass
    vt[0] = '{3'd2, 7'h13, 3'd0, 7'h00, 32'd7, 6'd0, 32'h100,
              1'b1, 32'd5, 3'd0, 1'b1, 32'd0, 3'd0,
              0, 3'd0, 32'd0, 32'd5, 32'd0, 1};
    vt[1] = '{3'd3, 7'h33, 3'd0, 7'h00, 32'd0, 6'd0, 32'h104,
              1'b0, 32'd0, 3'd1, 1'b1, 32'd4, 3'd0,
              1, 3'd1, 32'd10, 32'd10, 32'd4, 2};
    vt[2] = '{3'd3, 7'h33, 3'd0, 7'h00, 32'd0, 6'd0, 32'h108,
              1'b0, 32'd0, 3'd1, 1'b1, 32'd4, 3'd0,
              2, 3'd1, 32'd10, 32'd10, 32'd4, 2};
    vt[3] = '{3'd5, 7'h33, 3'd0, 7'h20, 32'd0, 6'd0, 32'h10c,
              1'b0, 32'd0, 3'd6, 1'b1, 32'd1, 3'd0,
              3, 3'd6, 32'hDEAD, 32'hDEAD, 32'd1, 1};
    vt[4] = '{3'd7, 7'h33, 3'd1, 7'h00, 32'd0, 6'd5, 32'h110,
              1'b1, 32'h11, 3'd0, 1'b0, 32'd0, 3'd0,
              2, 3'd0, 32'h22, 32'h11, 32'h22, 2};
    vt[5] = '{3'd1, 7'h63, 3'd1, 7'h00, 32'hFFFF_FFF0, 6'd0,
              32'h200, 1'b0, 32'd0, 3'd4, 1'b0, 32'd0, 3'd4,
              4, 3'd4, 32'hABC, 32'hABC, 32'hABC, 1};

    for (int v = 0; v < 6; v++) begin
      idle();
      dispatch_valid = 1'b1;
      dispatch_id = vt[v].id;
      dispatch_opcode = vt[v].opc;
      dispatch_funct3 = vt[v].f3;
      dispatch_funct7 = vt[v].f7;
      dispatch_imm = vt[v].imm;
      dispatch_shamt = vt[v].sh;
      dispatch_pc = vt[v].pc;
      dispatch_rs1_ready = vt[v].r1r;
      dispatch_rs1_val = vt[v].r1v;
      dispatch_rs1_dep = vt[v].r1d;
      dispatch_rs2_ready = vt[v].r2r;
      dispatch_rs2_val = vt[v].r2v;
      dispatch_rs2_dep = vt[v].r2d;
      alu_cdb_id = vt[v].bid; alu_cdb_val = vt[v].bval;
      lsb_cdb_id = vt[v].bid; lsb_cdb_val = vt[v].bval;
      alu_cdb_valid = (vt[v].bus == 3);
      lsb_cdb_valid = (vt[v].bus == 4);
      step();
      idle();
      alu_cdb_valid = (vt[v].bus == 1);
      lsb_cdb_valid = (vt[v].bus == 2);
      lat = 0; nstrb = 0;
      c_id = '1; c1 = '1; c2 = '1; c_imm = '1;
      c_pc = '1; c_dec = '1;
      for (int c = 1; c <= 4; c++) begin
        step();
        idle();
        if (have_ins) begin
          nstrb++;
          if (lat == 0) begin
            lat = c;
            c_id = 32'(ins_id); c1 = rs1_val; c2 = rs2_val;
            c_imm = imm_val; c_pc = request_PC;
            c_dec = 32'({opcode, funct3, funct7, shamt_val});
          end
        end
      end
      chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vt[v].lat));
      chk($sformatf("v%0d_strobes", v), 32'(nstrb), 1);
      chk($sformatf("v%0d_id", v), c_id, 32'(vt[v].id));
      chk($sformatf("v%0d_rs1", v), c1, vt[v].e1);
      chk($sformatf("v%0d_rs2", v), c2, vt[v].e2);
      chk($sformatf("v%0d_imm", v), c_imm, vt[v].imm);
      chk($sformatf("v%0d_pc", v), c_pc, vt[v].pc);
      chk($sformatf("v%0d_dec", v), c_dec,
          32'({vt[v].opc, vt[v].f3, vt[v].f7, vt[v].sh}));
    end

    // Fill, drop when full, out-of-order wake, full boundary.
    idle();
    for (int i = 0; i < 4; i++) begin
      disp(3'(i), 1'b0, 32'd0, 3'(i + 4),
           1'b1, 32'h100 + 32'(i), 3'd0, 32'd0);
      step();
    end
    idle();
    chk("full_set", 32'(rs_full), 1);
    disp(3'd4, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0, 32'd0);
    step();
    idle();
    chk("full_drop_noissue", 32'(have_ins), 0);
    chk("full_hold", 32'(rs_full), 1);
    alu_cdb_valid = 1'b1; alu_cdb_id = 3'd7;
    alu_cdb_val = 32'h33;
    lsb_cdb_valid = 1'b1; lsb_cdb_id = 3'd5;
    lsb_cdb_val = 32'h11;
    step();
    idle();
    chk("wake_noissue", 32'(have_ins), 0);
    chk("wake_still_full", 32'(rs_full), 1);
    disp(3'd6, 1'b1, 32'h66, 3'd0, 1'b1, 32'h6, 3'd0, 32'd0);
    step();
    chk("ord1_have", 32'(have_ins), 1);
    chk("ord1_id", 32'(ins_id), 1);
    chk("ord1_rs1", rs1_val, 32'h11);
    chk("ord1_rs2", rs2_val, 32'h101);
    chk("full_clear", 32'(rs_full), 0);
    step();
    idle();
    chk("ord2_have", 32'(have_ins), 1);
    chk("ord2_id", 32'(ins_id), 3);
    chk("ord2_rs1", rs1_val, 32'h33);
    step();
    chk("held_have", 32'(have_ins), 1);
    chk("held_id", 32'(ins_id), 6);
    chk("held_rs1", rs1_val, 32'h66);
    step();
    chk("held_once", 32'(have_ins), 0);

    // Flush with three busy entries (0, 1, 2).
    disp(3'd5, 1'b0, 32'd0, 3'd3, 1'b1, 32'd9, 3'd0, 32'd0);
    step();
    idle();
    chk("pre_flush_full", 32'(rs_full), 0);
    flush_pipline = 1'b1;
    disp(3'd7, 1'b1, 32'h70, 3'd0, 1'b1, 32'h71, 3'd0, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_id = 3'd4;
    alu_cdb_val = 32'h44;
    step();
    idle();
    chk("flush_have", 32'(have_ins), 0);
    chk("flush_full", 32'(rs_full), 0);
    nstrb = 0;
    alu_cdb_valid = 1'b1; alu_cdb_id = 3'd6;
    lsb_cdb_valid = 1'b1; lsb_cdb_id = 3'd3;
    step();
    idle();
    if (have_ins) nstrb++;
    alu_cdb_valid = 1'b1; alu_cdb_id = 3'd4;
    for (int c = 0; c < 4; c++) begin
      step();
      idle();
      if (have_ins) nstrb++;
    end
    chk("flush_quiet", 32'(nstrb), 0);

    // Stall: ready entry waits while rdy_in is low.
    disp(3'd2, 1'b1, 32'h77, 3'd0, 1'b1, 32'd0, 3'd0, 32'h5);
    step();
    idle();
    rdy_in = 1'b0;
    disp(3'd3, 1'b1, 32'h55, 3'd0, 1'b1, 32'd0, 3'd0, 32'h9);
    alu_cdb_valid = 1'b1; alu_cdb_id = 3'd0;
    nstrb = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (have_ins) nstrb++;
    end
    chk("stall_quiet", 32'(nstrb), 0);
    idle();
    step();
    chk("stall_have", 32'(have_ins), 1);
    chk("stall_id", 32'(ins_id), 2);
    chk("stall_rs1", rs1_val, 32'h77);
    chk("stall_imm", imm_val, 32'h5);
    step();
    chk("stall_drop", 32'(have_ins), 0);

    // Asynchronous reset in the middle of activity.
    disp(3'd1, 1'b1, 32'h99, 3'd0, 1'b1, 32'd0, 3'd0, 32'd0);
    step();
    disp(3'd2, 1'b1, 32'h98, 3'd0, 1'b1, 32'd0, 3'd0, 32'd0);
    step();
    idle();
    chk("mr_pre_have", 32'(have_ins), 1);
    #1 rst_in = 1'b1;
    #1;
    chk("mr_have", 32'(have_ins), 0);
    chk("mr_id", 32'(ins_id), 0);
    chk("mr_rs1", rs1_val, 0);
    chk("mr_full", 32'(rs_full), 0);
    #1 rst_in = 1'b0;
    nstrb = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (have_ins) nstrb++;
    end
    chk("mr_quiet", 32'(nstrb), 0);

    // Randomized run against the slot model.
    for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit e_have;
      logic [2:0] e_id;
      logic [31:0] e1, e2, e_imm;
      int j, f, n;
      rdy_in = ($urandom_range(9) != 0);
      flush_pipline = ($urandom_range(39) == 0);
      dispatch_valid = $urandom_range(1) != 0;
      dispatch_id = 3'($urandom_range(7));
      dispatch_imm = $urandom;
      dispatch_rs1_ready = $urandom_range(1) != 0;
      dispatch_rs2_ready = $urandom_range(1) != 0;
      dispatch_rs1_val = $urandom;
      dispatch_rs2_val = $urandom;
      dispatch_rs1_dep = 3'($urandom_range(7));
      dispatch_rs2_dep = 3'($urandom_range(7));
      alu_cdb_valid = ($urandom_range(4) < 2);
      alu_cdb_id = 3'($urandom_range(7));
      alu_cdb_val = $urandom;
      lsb_cdb_valid = ($urandom_range(4) < 2);
      lsb_cdb_id = 3'($urandom_range(7));
      lsb_cdb_val = $urandom;
      if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_id == lsb_cdb_id)
        lsb_cdb_id = alu_cdb_id + 3'd1;

      j = -1; f = -1; n = 0;
      e_have = 1'b0; e_id = '0; e1 = '0; e2 = '0; e_imm = '0;
      for (int i = 0; i < 4; i++) begin
        if (m[i].busy) n++;
        if (m[i].busy && m[i].r1 && m[i].r2 && j < 0) j = i;
        if (!m[i].busy && f < 0) f = i;
      end
      chk("rnd_full", 32'(rs_full), 32'(n == 4));
      if (rdy_in && flush_pipline) begin
        for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
      end else if (rdy_in) begin
        if (j >= 0) begin
          e_have = 1'b1;
          e_id = m[j].id; e1 = m[j].v1; e2 = m[j].v2;
          e_imm = m[j].imm;
          m[j].busy = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
          if (m[i].busy) begin
            {m[i].r1, m[i].v1} = res(m[i].r1, m[i].v1, m[i].d1);
            {m[i].r2, m[i].v2} = res(m[i].r2, m[i].v2, m[i].d2);
          end
        end
        if (dispatch_valid && n < 4) begin
          m[f].busy = 1'b1;
          m[f].id = dispatch_id;
          m[f].imm = dispatch_imm;
          m[f].d1 = dispatch_rs1_dep;
          m[f].d2 = dispatch_rs2_dep;
          {m[f].r1, m[f].v1} = res(dispatch_rs1_ready,
                                   dispatch_rs1_val,
                                   dispatch_rs1_dep);
          {m[f].r2, m[f].v2} = res(dispatch_rs2_ready,
                                   dispatch_rs2_val,
                                   dispatch_rs2_dep);
        end
      end
      step();
      chk("rnd_have", 32'(have_ins), 32'(e_have));
      if (e_have) begin
        chk("rnd_id", 32'(ins_id), 32'(e_id));
        chk("rnd_rs1", rs1_val, e1);
        chk("rnd_rs2", rs2_val, e2);
        chk("rnd_imm", imm_val, e_imm);
      end
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
